restoring_div_core: RTL and testbench

Parametrised sequential restoring divider with signed/unsigned mode, valid/ready handshakes on both input and result, and divide-by-zero / signed-overflow flags. Successor to the fixed 16-bit divider. Sits between operand-capture front ends (push-button or bus registers) and display/consumer logic. One division in flight; one quotient bit per cycle.

---
 rtl/div_pkg.sv | 14 +
 rtl/restoring_div_step.sv | 28 ++
 rtl/restoring_div_core.sv | 154 +++++++++++++++
 tb/tb_restoring_div_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the restoring divider family.
package div_pkg;

  localparam int DIV_MIN_WIDTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIVIDE,
    FIXUP,
    DONE
  } div_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {acc, q} left, trial-subtract the divisor, keep or restore.
module restoring_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] acc_sh;
  logic [WIDTH:0] trial;

  // The shifted accumulator needs WIDTH+1 bits, so the borrow (not acc MSB) decides the quotient bit.
  always_comb begin
    acc_sh = {acc_i, q_i[WIDTH-1]};
    trial  = acc_sh - {1'b0, divisor_i};
    if (trial[WIDTH]) begin
      acc_o = acc_sh[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = trial[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_div_core.sv
// Sequential restoring divider, one quotient bit per cycle, signed/unsigned, valid/ready on both sides.
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// PREP   | divide-by-zero check, magnitude conversion, sign bookkeeping
// DIVIDE | WIDTH shift/subtract iterations
// FIXUP  | apply quotient/remainder signs
// DONE   | result held until out_ready
module restoring_div_core
  import div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_acc, step_q;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .acc_o     (step_acc),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d      = dividend;
          dvs_d    = divisor;
          acc_d    = '0;
          signed_d = SIGNED_EN & signed_op;
          q_neg_d  = 1'b0;
          r_neg_d  = 1'b0;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
          state_d  = PREP;
        end
      end
      PREP: begin
        // Zero check runs on the latched divisor so the accept path stays a plain register load.
        if (dvs_q == '0) begin
          q_d     = '1;
          acc_d   = q_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (signed_q) begin
            q_neg_d = q_q[WIDTH-1] ^ dvs_q[WIDTH-1];
            r_neg_d = q_q[WIDTH-1];
            q_d     = abs_val(q_q);
            dvs_d   = abs_val(dvs_q);
            ovf_d   = (q_q == MOST_NEG) && (dvs_q == '1);
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (q_neg_q) q_d = ~q_q + 1'b1;
        if (r_neg_q) acc_d = ~acc_q + 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = acc_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_restoring_div_core.sv
// Self-checking bench for restoring_div_core at WIDTH=16 (signed) and WIDTH=8 (signed mode disabled).
module tb_restoring_div_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid16, in_ready16, signed16, out_valid16, out_ready16;
  logic [15:0] dividend16, divisor16, quotient16, remainder16;
  logic        dbz16, ovf16, busy16;

  logic        in_valid8, in_ready8, signed8, out_valid8, out_ready8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        dbz8, ovf8, busy8;

  restoring_div_core #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .signed_op(signed16),
    .dividend(dividend16), .divisor(divisor16), .out_valid(out_valid16), .out_ready(out_ready16),
    .quotient(quotient16), .remainder(remainder16), .div_by_zero(dbz16), .overflow(ovf16),
    .busy(busy16)
  );

  restoring_div_core #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .signed_op(signed8),
    .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8), .overflow(ovf8),
    .busy(busy8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run16(input vec_t v, input bit hold);
    vec_t e;
    int   cyc;
    sb.push_back(v);
    @(negedge clk);
    cyc = 0;
    while (!in_ready16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_before_accept", in_ready16, 1);
    in_valid16  = 1'b1;
    dividend16  = v.a;
    divisor16   = v.b;
    signed16    = v.s;
    out_ready16 = !hold;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    dividend16 = ~v.a;
    divisor16  = 16'h0;
    signed16   = ~v.s;
    chk("busy_after_accept", busy16, 1);
    cyc = 0;
    while (!out_valid16 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("quotient", quotient16, e.q);
    chk("remainder", remainder16, e.r);
    chk("div_by_zero", dbz16, e.dbz);
    chk("overflow", ovf16, e.ovf);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        if (i == 1) begin
          in_valid16 = 1'b1;
          dividend16 = 16'd50;
          divisor16  = 16'd5;
          signed16   = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("hold_out_valid", out_valid16, 1);
        chk("hold_in_ready", in_ready16, 0);
        chk("hold_quotient", quotient16, e.q);
        chk("hold_remainder", remainder16, e.r);
      end
      in_valid16  = 1'b0;
      out_ready16 = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("in_ready_after_consume", in_ready16, 1);
    chk("out_valid_after_consume", out_valid16, 0);
    chk("flag_dbz_persist", dbz16, e.dbz);
    chk("flag_ovf_persist", ovf16, e.ovf);
    if (hold) chk("quotient_after_ignored_valid", quotient16, e.q);
    out_ready16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vec_t v;
    rst = 1'b1;
    in_valid16 = 0; signed16 = 0; out_ready16 = 0; dividend16 = 0; divisor16 = 0;
    in_valid8 = 0; signed8 = 0; out_ready8 = 0; dividend8 = 0; divisor8 = 0;

    vecs[0]  = '{16'd1000, 16'd7,    1'b0, 16'd142,  16'd6,    1'b0, 1'b0, 18};
    vecs[1]  = '{16'hFFFF, 16'h8001, 1'b0, 16'd1,    16'h7FFE, 1'b0, 1'b0, 18};
    vecs[2]  = '{16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[3]  = '{16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0, 1'b0, 18};
    vecs[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0,    1'b0, 1'b1, 18};
    vecs[5]  = '{16'd1234, 16'd0,    1'b0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 1};
    vecs[6]  = '{16'hFFF9, 16'd2,    1'b0, 16'h7FFC, 16'd1,    1'b0, 1'b0, 18};
    vecs[7]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'd14,   16'hFFFE, 1'b0, 1'b0, 18};
    vecs[8]  = '{16'hFF9C, 16'd0,    1'b1, 16'hFFFF, 16'hFF9C, 1'b1, 1'b0, 1};
    vecs[9]  = '{16'h8000, 16'hFFFF, 1'b0, 16'd0,    16'h8000, 1'b0, 1'b0, 18};
    vecs[10] = '{16'd5,    16'd9,    1'b0, 16'd0,    16'd5,    1'b0, 1'b0, 18};
    vecs[11] = '{16'hFFFF, 16'd1,    1'b0, 16'hFFFF, 16'd0,    1'b0, 1'b0, 18};

    #12;
    chk("rst_in_ready", in_ready16, 0);
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_quotient", quotient16, 0);
    chk("rst_remainder", remainder16, 0);
    chk("rst_flags", {dbz16, ovf16}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready16, 1);

    for (int i = 0; i < 12; i++) run16(vecs[i], 1'b0);

    // Stall the consumer on an overflow result and poke in_valid while busy.
    run16(vecs[4], 1'b1);

    // Asynchronous reset in the middle of the DIVIDE iterations.
    @(negedge clk);
    in_valid16 = 1'b1;
    dividend16 = 16'hFFFF;
    divisor16  = 16'd3;
    signed16   = 1'b0;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy16, 1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready16, 0);
    chk("midrst_out_valid", out_valid16, 0);
    chk("midrst_busy", busy16, 0);
    chk("midrst_quotient", quotient16, 0);
    chk("midrst_remainder", remainder16, 0);
    chk("midrst_flags", {dbz16, ovf16}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", in_ready16, 1);
    v = '{16'd100, 16'd10, 1'b0, 16'd10, 16'd0, 1'b0, 1'b0, 18};
    run16(v, 1'b0);

    // WIDTH=8 instance with signed mode compiled out: signed_op must be ignored.
    @(negedge clk);
    chk("w8_in_ready", in_ready8, 1);
    in_valid8  = 1'b1;
    dividend8  = 8'd200;
    divisor8   = 8'd3;
    signed8    = 1'b1;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    dividend8 = 8'd0;
    cyc = 0;
    while (!out_valid8 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("w8_latency", cyc, 10);
    chk("w8_quotient", quotient8, 8'd66);
    chk("w8_remainder", remainder8, 8'd2);
    chk("w8_flags", {dbz8, ovf8}, 0);
    @(posedge clk);
    #1;
    chk("w8_in_ready_after", in_ready8, 1);
    out_ready8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
